// File: rtl/rdma_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rdma_responder                                                  |
// | Brief    : RDMA header loopback peer: 4-word request in, swapped reply out. |
// |            Optional macro RDMA_RESP_FILTER_EN suppresses replies to op=0.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module rdma_responder #(
  parameter int DROP_CNT_W = 8,
  parameter int CNT_INC    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           data_slave,
  input  logic [3:0]            keep_slave,
  input  logic                  valid_slave,
  input  logic                  last_slave,
  output logic                  ready_slave,
  output logic [31:0]           data_master,
  output logic [3:0]            keep_master,
  output logic                  valid_master,
  output logic                  last_master,
  input  logic                  ready_master,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {
    ST_RX      = 2'd0,
    ST_DISCARD = 2'd1,
    ST_TX      = 2'd2
  } state_t;

  localparam logic [3:0]            KEEP_ALL  = 4'hF;
  localparam logic [DROP_CNT_W-1:0] DROP_MAX  = '1;
  localparam logic [30:0]           CNT_INC_W = 31'(CNT_INC);

  state_t                  state_q;
  logic [1:0]              idx_q;
  logic [47:0]             src_q;
  logic [47:0]             dst_q;
  logic                    op_q;
  logic [30:0]             cnt_q;
  logic                    ready_slave_q;
  logic [31:0]             data_master_q;
  logic [3:0]              keep_master_q;
  logic                    valid_master_q;
  logic                    last_master_q;
  logic                    busy_q;
  logic [DROP_CNT_W-1:0]   drop_count_q;

  logic                    rx_fire;
  logic                    tx_fire;
  logic                    rx_bad;
  logic                    reply_en;
  logic [1:0]              tx_idx_d;
  logic [31:0]             tx_word_d;
  logic [DROP_CNT_W-1:0]   drop_count_d;

  assign rx_fire = valid_slave & ready_slave_q;
  assign tx_fire = valid_master_q & ready_master;

  // A word is malformed if bytes are missing or last does not coincide with word 3.
  assign rx_bad  = (keep_slave != KEEP_ALL) || (last_slave != (idx_q == 2'd3));

`ifdef RDMA_RESP_FILTER_EN
  assign reply_en = data_slave[31];
`else
  assign reply_en = 1'b1;
`endif

  assign drop_count_d = (drop_count_q == DROP_MAX) ? drop_count_q : drop_count_q + 1'b1;

  // Word 0 is loaded on entry to TX, later words on each reply handshake.
  assign tx_idx_d = (state_q == ST_TX) ? idx_q + 2'd1 : 2'd0;

  always_comb begin
    tx_word_d = 32'h0;
    case (tx_idx_d)
      2'd0:    tx_word_d = src_q[47:16];
      2'd1:    tx_word_d = {src_q[15:0], dst_q[47:32]};
      2'd2:    tx_word_d = dst_q[31:0];
      default: tx_word_d = {op_q, cnt_q + CNT_INC_W};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RX;
      idx_q          <= 2'd0;
      src_q          <= 48'h0;
      dst_q          <= 48'h0;
      op_q           <= 1'b0;
      cnt_q          <= 31'h0;
      ready_slave_q  <= 1'b0;
      data_master_q  <= 32'h0;
      keep_master_q  <= 4'h0;
      valid_master_q <= 1'b0;
      last_master_q  <= 1'b0;
      busy_q         <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      case (state_q)
        ST_RX: begin
          ready_slave_q <= 1'b1;
          if (rx_fire) begin
            if (rx_bad) begin
              drop_count_q <= drop_count_d;
              idx_q        <= 2'd0;
              if (!last_slave) begin
                state_q <= ST_DISCARD;
              end
            end else begin
              case (idx_q)
                2'd0: dst_q[47:16] <= data_slave;
                2'd1: begin
                  dst_q[15:0]  <= data_slave[31:16];
                  src_q[47:32] <= data_slave[15:0];
                end
                2'd2: src_q[31:0] <= data_slave;
                default: begin
                  op_q  <= data_slave[31];
                  cnt_q <= data_slave[30:0];
                end
              endcase
              if (idx_q == 2'd3) begin
                idx_q <= 2'd0;
                if (reply_en) begin
                  state_q        <= ST_TX;
                  ready_slave_q  <= 1'b0;
                  valid_master_q <= 1'b1;
                  busy_q         <= 1'b1;
                  keep_master_q  <= KEEP_ALL;
                  last_master_q  <= 1'b0;
                  data_master_q  <= tx_word_d;
                end
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
          end
        end

        ST_DISCARD: begin
          ready_slave_q <= 1'b1;
          if (rx_fire && last_slave) begin
            state_q <= ST_RX;
            idx_q   <= 2'd0;
          end
        end

        ST_TX: begin
          if (tx_fire) begin
            if (idx_q == 2'd3) begin
              state_q        <= ST_RX;
              idx_q          <= 2'd0;
              ready_slave_q  <= 1'b1;
              valid_master_q <= 1'b0;
              last_master_q  <= 1'b0;
              keep_master_q  <= 4'h0;
              data_master_q  <= 32'h0;
              busy_q         <= 1'b0;
            end else begin
              idx_q         <= idx_q + 2'd1;
              data_master_q <= tx_word_d;
              last_master_q <= (idx_q == 2'd2);
            end
          end
        end

        default: begin
          state_q <= ST_RX;
          idx_q   <= 2'd0;
        end
      endcase
    end
  end

  assign ready_slave  = ready_slave_q;
  assign data_master  = data_master_q;
  assign keep_master  = keep_master_q;
  assign valid_master = valid_master_q;
  assign last_master  = last_master_q;
  assign busy         = busy_q;
  assign drop_count   = drop_count_q;

endmodule
`default_nettype wire
